axis_fifo_counted: RTL and testbench



---
 rtl/axis_fifo_counted.sv | 91 +++++++++
 tb/tb_axis_fifo_counted.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_counted.sv
// axis_fifo_counted: first-word-fall-through AXI-Stream FIFO of arbitrary depth.
// It reports occupancy and has threshold-programmable almost_full/almost_empty flags.
// Optional feature macro: AXIS_FIFO_FLUSH_EN adds the flush input.
// When it is defined, flush discards all contents at the next edge.
module axis_fifo_counted #(
  parameter int DATA_WIDTH             = 32,
  parameter int FIFO_DEPTH             = 16,
  parameter int ALMOST_FULL_THRESHOLD  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               input_valid,
  output logic                               input_ready,
  input  logic [DATA_WIDTH-1:0]              input_data,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic [DATA_WIDTH-1:0]              output_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy,
  output logic                               almost_full,
  output logic                               almost_empty
`ifdef AXIS_FIFO_FLUSH_EN
  ,
  input  logic                               flush
`endif
);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] AF_C    = OCC_W'(ALMOST_FULL_THRESHOLD);
  localparam logic [OCC_W-1:0] AE_C    = OCC_W'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  // Bad configurations stop elaboration rather than build a broken FIFO.
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "axis_fifo_counted: FIFO_DEPTH must be >= 2");
  end
  if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > FIFO_DEPTH) begin : g_bad_af
    $fatal(1, "axis_fifo_counted: ALMOST_FULL_THRESHOLD out of range 1..FIFO_DEPTH");
  end
  if (ALMOST_EMPTY_THRESHOLD < 0 || ALMOST_EMPTY_THRESHOLD > FIFO_DEPTH - 1) begin : g_bad_ae
    $fatal(1, "axis_fifo_counted: ALMOST_EMPTY_THRESHOLD out of range 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  flush_act;
  logic                  wr_fire, rd_fire;

`ifdef AXIS_FIFO_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // A flush cycle blocks both handshakes, so nothing moves while contents are dropped.
  // There is no full-bypass: a full FIFO refuses a write even if a read happens in the same cycle.
  assign input_ready  = !rst && !flush_act && (occ < DEPTH_C);
  assign output_valid = !flush_act && (occ != '0);
  assign output_data  = output_valid ? mem[rd_ptr] : '0;
  assign wr_fire      = input_valid && input_ready;
  assign rd_fire      = output_valid && output_ready;

  // Flags are derived from registered occupancy only, so they cannot glitch within a cycle.
  assign occupancy    = occ;
  assign almost_full  = (occ >= AF_C);
  assign almost_empty = (occ <= AE_C);

  // Storage write. It is not reset, because stale contents are never visible past occupancy.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= input_data;
  end

  // Pointers wrap explicitly at FIFO_DEPTH-1, which allows depths that are not a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_fifo_counted.sv
// Bench for axis_fifo_counted.
// Two instances are used: depth 16 (32-bit data) and depth 5 (8-bit data).
// Each instance is checked against a queue model of FIFO behaviour.
module tb_axis_fifo_counted;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fl;
  logic        v16, r16, rdy16, ov16, af16, ae16;
  logic [31:0] din16, dout16;
  logic [4:0]  occ16;
  logic        v5, r5, rdy5, ov5, af5, ae5;
  logic [7:0]  din5, dout5;
  logic [2:0]  occ5;

  int n_cmp = 0, n_bad = 0, n_acc = 0;
  logic [31:0] q16[$], got16[$];
  logic [7:0]  q5[$], got5[$], sent5[$];
  logic [7:0]  words5[23];

  axis_fifo_counted #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) d16 (
    .clk(clk), .rst(rst),
    .input_valid(v16), .input_ready(rdy16), .input_data(din16),
    .output_valid(ov16), .output_ready(r16), .output_data(dout16),
    .occupancy(occ16), .almost_full(af16), .almost_empty(ae16)
`ifdef AXIS_FIFO_FLUSH_EN
    , .flush(fl)
`endif
  );

  axis_fifo_counted #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) d5 (
    .clk(clk), .rst(rst),
    .input_valid(v5), .input_ready(rdy5), .input_data(din5),
    .output_valid(ov5), .output_ready(r5), .output_data(dout5),
    .occupancy(occ5), .almost_full(af5), .almost_empty(ae5)
`ifdef AXIS_FIFO_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all registered-state outputs with the model after an edge.
  task automatic check_outs();
    bit e_ov16, e_ov5;
    e_ov16 = !fl && (q16.size() > 0);
    e_ov5  = (q5.size() > 0);
    chk("occ16",  {27'd0, occ16}, q16.size());
    chk("ov16",   {31'd0, ov16},  {31'd0, e_ov16});
    chk("dout16", dout16,         e_ov16 ? q16[0] : 32'd0);
    chk("af16",   {31'd0, af16},  (q16.size() >= 14) ? 32'd1 : 32'd0);
    chk("ae16",   {31'd0, ae16},  (q16.size() <= 1)  ? 32'd1 : 32'd0);
    chk("occ5",   {29'd0, occ5},  q5.size());
    chk("ov5",    {31'd0, ov5},   {31'd0, e_ov5});
    chk("dout5",  {24'd0, dout5}, e_ov5 ? {24'd0, q5[0]} : 32'd0);
    chk("af5",    {31'd0, af5},   (q5.size() >= 3) ? 32'd1 : 32'd0);
    chk("ae5",    {31'd0, ae5},   (q5.size() <= 1) ? 32'd1 : 32'd0);
  endtask

  // One clock: check ready, predict handshakes, advance the model, then check outputs.
  task automatic tick();
    bit e_rdy16, wr16, rd16, e_rdy5, wr5, rd5;
    #1;
    e_rdy16 = !rst && !fl && (q16.size() < 16);
    e_rdy5  = !rst && (q5.size() < 5);
    chk("rdy16", {31'd0, rdy16}, {31'd0, e_rdy16});
    chk("rdy5",  {31'd0, rdy5},  {31'd0, e_rdy5});
    wr16 = v16 && e_rdy16;
    rd16 = r16 && !fl && (q16.size() > 0);
    wr5  = v5 && e_rdy5;
    rd5  = r5 && (q5.size() > 0);
    if (v16 && rdy16) n_acc++;
    if (rd16) got16.push_back(dout16);
    if (rd5)  got5.push_back(dout5);
    @(posedge clk);
    if (rst) begin
      q16.delete();
      q5.delete();
    end else begin
      if (fl) q16.delete();
      else begin
        if (rd16) void'(q16.pop_front());
        if (wr16) q16.push_back(din16);
      end
      if (rd5) void'(q5.pop_front());
      if (wr5) begin
        q5.push_back(din5);
        sent5.push_back(din5);
      end
    end
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    int prev;
    rst = 1'b1; fl = 1'b0;
    v16 = 1'b0; r16 = 1'b0; din16 = '0;
    v5 = 1'b0; r5 = 1'b0; din5 = '0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rdy16", {31'd0, rdy16}, 32'd1);
    chk("rst_ae16",  {31'd0, ae16},  32'd1);
    chk("rst_occ16", {27'd0, occ16}, 32'd0);
    tick();

    // Fill with 1,2,3,... while the consumer is stalled.
    n_acc = 0; din16 = 32'd1; v16 = 1'b1; r16 = 1'b0;
    repeat (20) begin
      prev = q16.size();
      tick();
      if (q16.size() > prev) din16 = din16 + 32'd1;
    end
    chk("fill_acc", n_acc, 32'd16);
    chk("fill_occ", {27'd0, occ16}, 32'd16);
    chk("fill_rdy", {31'd0, rdy16}, 32'd0);
    chk("fill_af",  {31'd0, af16},  32'd1);

    // Drain: words 1..16 in order.
    got16.delete();
    v16 = 1'b0; r16 = 1'b1;
    repeat (18) tick();
    chk("drain_n", got16.size(), 32'd16);
    for (int i = 0; i < got16.size() && i < 16; i++)
      chk("drain_word", got16[i], i + 1);
    chk("drain_ov",  {31'd0, ov16},  32'd0);
    chk("drain_occ", {27'd0, occ16}, 32'd0);

    // Simultaneous read and write at occupancy 3.
    r16 = 1'b0; v16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din16 = 32'd100 + i;
      tick();
    end
    din16 = 32'd103; r16 = 1'b1;
    tick();
    chk("rw_occ",  {27'd0, occ16}, 32'd3);
    chk("rw_head", dout16, 32'd101);

    // Go full, then offer read and write together: the write waits one cycle.
    r16 = 1'b0;
    repeat (20) if (q16.size() < 16) begin
      din16 = din16 + 32'd1;
      tick();
    end
    chk("full_occ", {27'd0, occ16}, 32'd16);
    din16 = 32'd500; r16 = 1'b1; v16 = 1'b1;
    tick();
    chk("full_refuse", {27'd0, occ16}, 32'd15);
    r16 = 1'b0;
    tick();
    chk("full_accept", {27'd0, occ16}, 32'd16);

    // Reset mid-stream at occupancy 7.
    v16 = 1'b0; r16 = 1'b1;
    repeat (9) tick();
    chk("pre_rst_occ", {27'd0, occ16}, 32'd7);
    rst = 1'b1; v16 = 1'b1; r16 = 1'b1;
    tick();
    rst = 1'b0; v16 = 1'b0; r16 = 1'b0;
    #1;
    chk("mid_rst_ov",  {31'd0, ov16},  32'd0);
    chk("mid_rst_occ", {27'd0, occ16}, 32'd0);
    chk("mid_rst_ae",  {31'd0, ae16},  32'd1);
    chk("mid_rst_rdy", {31'd0, rdy16}, 32'd1);
    tick();

`ifdef AXIS_FIFO_FLUSH_EN
    // Same check using a single-cycle flush pulse.
    v16 = 1'b1;
    repeat (7) begin
      din16 = $urandom;
      tick();
    end
    chk("pre_fl_occ", {27'd0, occ16}, 32'd7);
    fl = 1'b1; r16 = 1'b1;
    tick();
    fl = 1'b0; v16 = 1'b0; r16 = 1'b0;
    #1;
    chk("fl_ov",  {31'd0, ov16},  32'd0);
    chk("fl_occ", {27'd0, occ16}, 32'd0);
    chk("fl_ae",  {31'd0, ae16},  32'd1);
    chk("fl_rdy", {31'd0, rdy16}, 32'd1);
    tick();
`endif

    // Random traffic on the depth-16 instance.
    repeat (300) begin
      v16 = 1'($urandom_range(0, 1));
      r16 = 1'($urandom_range(0, 1));
      din16 = $urandom;
      tick();
    end
    v16 = 1'b0; r16 = 1'b0;

    // Depth 5: 23 words with random valid/ready, exercising pointer wrap.
    for (int i = 0; i < 23; i++) words5[i] = 8'($urandom);
    sent5.delete(); got5.delete();
    repeat (400) if (got5.size() < 23) begin
      v5 = (sent5.size() < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      din5 = (sent5.size() < 23) ? words5[sent5.size()] : 8'd0;
      r5 = 1'($urandom_range(0, 1));
      tick();
      chk("occ5_max", (occ5 <= 3'd5) ? 32'd1 : 32'd0, 32'd1);
    end
    v5 = 1'b0; r5 = 1'b0;
    chk("wrap_n", got5.size(), 32'd23);
    for (int i = 0; i < got5.size() && i < 23; i++)
      chk("wrap_word", {24'd0, got5[i]}, {24'd0, words5[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
